mem_arbiter: RTL

Sequences and shares a single 16-bit external memory bus between the core's instruction-fetch port and its data-memory port. Instruction fetches are split into two 16-bit bus beats and reassembled into one I_SIZE word. Simultaneous requests are resolved round-robin. The block sits between `core` and the SoC memory/bus interconnect.

---
 rtl/mem_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RW-bit external bus between instruction fetch
// (two beats per I_SIZE word) and data access, round-robin on ties.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-low reset
//   i_fetch_req/addr      fetch request (level) and instruction index
//   o_fetch_data/valid    assembled instruction, one-cycle valid pulse
//   i_data_req/we/addr/wdata  data request, held until o_data_ack
//   o_data_rdata/ack      read data, one-cycle completion pulse
//   o_bus_req/we/addr/wdata   bus beat, held until i_bus_ack
//                             (addr bit RW: 1 = instruction space)
//   i_bus_rdata/ack       bus read data and beat completion
module mem_arbiter #(
  parameter int RW     = 16,
  parameter int I_SIZE = 2 * RW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_req,
  input  logic [RW-1:0]     i_fetch_addr,
  output logic [I_SIZE-1:0] o_fetch_data,
  output logic              o_fetch_valid,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [RW-1:0]     i_data_addr,
  input  logic [RW-1:0]     i_data_wdata,
  output logic [RW-1:0]     o_data_rdata,
  output logic              o_data_ack,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [RW:0]       o_bus_addr,
  output logic [RW-1:0]     o_bus_wdata,
  input  logic [RW-1:0]     i_bus_rdata,
  input  logic              i_bus_ack
);

  typedef enum logic [1:0] {
    IDLE,
    I_LO,
    I_HI,
    D_ACC
  } state_t;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [RW:0]   addr;
    logic [RW-1:0] wdata;
  } bus_t;

  state_t              state;
  state_t              state_nx;
  grant_t              last_gnt;
  grant_t              last_gnt_nx;
  logic [RW-1:0]       faddr;
  logic [RW-1:0]       faddr_nx;
  bus_t                bus;
  bus_t                bus_nx;
  logic [I_SIZE-1:0]   fdata;
  logic [I_SIZE-1:0]   fdata_nx;
  logic                fvalid;
  logic                fvalid_nx;
  logic [RW-1:0]       drdata;
  logic [RW-1:0]       drdata_nx;
  logic                dack;
  logic                dack_nx;

  logic                fetch_pend;
  logic                data_pend;
  logic                take_fetch;
  logic                take_data;
  logic                beat_done;

  // Instruction index i occupies bus words 2i and 2i+1 of
  // the instruction space.
  function automatic logic [RW:0] ibeat(
    input logic [RW-1:0] a,
    input logic          hi
  );
    return {1'b1, a[RW-2:0], hi};
  endfunction

  // A requester drops its level in the cycle of its own pulse,
  // so that cycle's request must not start a second access.
  assign fetch_pend = i_fetch_req && !fvalid;
  assign data_pend  = i_data_req && !dack;

  assign take_fetch = fetch_pend &&
                      (!data_pend || last_gnt == GNT_DATA);
  assign take_data  = data_pend && !take_fetch;

  assign beat_done  = bus.req && i_bus_ack;

  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    faddr_nx    = faddr;
    bus_nx      = bus;
    fdata_nx    = fdata;
    fvalid_nx   = 1'b0;
    drdata_nx   = drdata;
    dack_nx     = 1'b0;

    unique case (state)
      IDLE: begin
        unique case (1'b1)
          take_fetch: begin
            state_nx     = I_LO;
            last_gnt_nx  = GNT_FETCH;
            faddr_nx     = i_fetch_addr;
            bus_nx.req   = 1'b1;
            bus_nx.we    = 1'b0;
            bus_nx.addr  = ibeat(i_fetch_addr, 1'b0);
            bus_nx.wdata = '0;
          end
          take_data: begin
            state_nx     = D_ACC;
            last_gnt_nx  = GNT_DATA;
            bus_nx.req   = 1'b1;
            bus_nx.we    = i_data_we;
            bus_nx.addr  = {1'b0, i_data_addr};
            bus_nx.wdata = i_data_wdata;
          end
          default: ;
        endcase
      end

      I_LO: begin
        if (beat_done) begin
          state_nx           = I_HI;
          fdata_nx[RW-1:0]   = i_bus_rdata;
          bus_nx.addr        = ibeat(faddr, 1'b1);
        end
      end

      // The high beat always finishes; a flushed or redirected
      // fetch is simply not reported.
      I_HI: begin
        if (beat_done) begin
          state_nx             = IDLE;
          fdata_nx[I_SIZE-1:RW] = i_bus_rdata;
          fvalid_nx  = i_fetch_req && (i_fetch_addr == faddr);
          bus_nx.req = 1'b0;
        end
      end

      D_ACC: begin
        if (beat_done) begin
          state_nx   = IDLE;
          dack_nx    = 1'b1;
          if (!bus.we) begin
            drdata_nx = i_bus_rdata;
          end
          bus_nx.req = 1'b0;
          bus_nx.we  = 1'b0;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= IDLE;
      last_gnt <= GNT_DATA;
      faddr    <= '0;
      bus      <= '0;
      fdata    <= '0;
      fvalid   <= 1'b0;
      drdata   <= '0;
      dack     <= 1'b0;
    end else begin
      state    <= state_nx;
      last_gnt <= last_gnt_nx;
      faddr    <= faddr_nx;
      bus      <= bus_nx;
      fdata    <= fdata_nx;
      fvalid   <= fvalid_nx;
      drdata   <= drdata_nx;
      dack     <= dack_nx;
    end
  end

  assign o_bus_req     = bus.req;
  assign o_bus_we      = bus.we;
  assign o_bus_addr    = bus.addr;
  assign o_bus_wdata   = bus.wdata;
  assign o_fetch_data  = fdata;
  assign o_fetch_valid = fvalid;
  assign o_data_rdata  = drdata;
  assign o_data_ack    = dack;

  // A presented beat may not move until it is acknowledged.
  a_bus_hold : assert property (
    @(posedge i_clk)
    i_rst && o_bus_req && !i_bus_ack |=>
      o_bus_req && $stable(o_bus_addr) &&
      $stable(o_bus_we) && $stable(o_bus_wdata)
  );

  // Only one port can complete per cycle.
  a_one_done : assert property (
    @(posedge i_clk)
    i_rst |-> !(o_fetch_valid && o_data_ack)
  );

endmodule
